// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // The iteration counter must be able to hold WIDTH itself, for example after the last step.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the EX stage (master) and the iterative divider (slave).
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic             annul_i;
  logic             ack_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] quot_o;
  logic [WIDTH-1:0] rem_o;
  logic             dbz_o;

  modport master (
    output start_i, signed_i, op1_i, op2_i, annul_i, ack_i,
    input  busy_o, valid_o, quot_o, rem_o, dbz_o
  );

  modport slave (
    input  start_i, signed_i, op1_i, op2_i, annul_i, ack_i,
    output busy_o, valid_o, quot_o, rem_o, dbz_o
  );
endinterface

// File: rtl/div_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module div_lzc
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]              i_data,
  output logic [cnt_width(WIDTH)-1:0]   o_lz
);
  localparam int CW = cnt_width(WIDTH);

  // NOTE: o_lz gets its default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_lz = CW'(WIDTH - 1 - i);
    end
  end
endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) with a valid/ack result handshake.
// Define DIV_EARLY_TERM_EN to skip the dividend's leading zeros (results are unchanged).
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  div_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic             r_signed, r_sgn1, r_sgn2;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot_o, r_rem_o;

  logic             w_accept, w_op2_zero, w_last, w_skip;
  logic [WIDTH-1:0] w_op1_mag, w_op2_mag, w_dvd_init;
  logic [CW-1:0]    w_cnt_init;
  logic [WIDTH:0]   w_shift, w_trial;

  assign w_accept   = (r_state == ST_IDLE) && bus.start_i && !bus.annul_i;
  assign w_op2_zero = (bus.op2_i == '0);
  assign w_op1_mag  = (bus.signed_i && bus.op1_i[WIDTH-1]) ? -bus.op1_i : bus.op1_i;
  assign w_op2_mag  = (bus.signed_i && bus.op2_i[WIDTH-1]) ? -bus.op2_i : bus.op2_i;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_TERM_EN
  logic [CW-1:0] w_lz;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .i_data (w_op1_mag),
    .o_lz   (w_lz)
  );

  // Leading zeros of the dividend would only produce quotient zeros; skip them up front.
  assign w_cnt_init = w_lz;
  assign w_dvd_init = w_op1_mag << w_lz;
  assign w_skip     = (w_lz == CW'(WIDTH));
`else
  assign w_cnt_init = '0;
  assign w_dvd_init = w_op1_mag;
  assign w_skip     = 1'b0;
`endif

  assign w_shift = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_op2_zero ? ST_DONE : (w_skip ? ST_FIX : ST_BUSY);
      ST_BUSY: begin
        if (bus.annul_i)  w_state_nxt = ST_IDLE;
        else if (w_last)  w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = bus.annul_i ? ST_IDLE : ST_DONE;
      ST_DONE: if (bus.ack_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dbz    <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_cnt_init;
        r_dbz <= w_op2_zero;
        if (w_op2_zero) begin
          r_quot_o <= '0;
          r_rem_o  <= '0;
        end
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // Truncating division: quotient negative iff signs differ, remainder follows the dividend.
      if (r_state == ST_FIX && !bus.annul_i) begin
        r_quot_o <= (r_signed && (r_sgn1 ^ r_sgn2)) ? -r_quot : r_quot;
        r_rem_o  <= (r_signed && r_sgn1) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      end
      if (r_state == ST_DONE && bus.ack_i) r_dbz <= 1'b0;
    end
  end

  // NOTE: the datapath is left unreset; it is always loaded on accept before anything reads it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem    <= '0;
      r_quot   <= w_dvd_init;
      r_div    <= w_op2_mag;
      r_signed <= bus.signed_i;
      r_sgn1   <= bus.op1_i[WIDTH-1];
      r_sgn2   <= bus.op2_i[WIDTH-1];
    end else if (r_state == ST_BUSY) begin
      if (!w_trial[WIDTH]) begin
        r_rem  <= w_trial;
        r_quot <= {r_quot[WIDTH-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift;
        r_quot <= {r_quot[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign bus.busy_o  = (r_state != ST_IDLE);
  assign bus.valid_o = (r_state == ST_DONE);
  assign bus.quot_o  = r_quot_o;
  assign bus.rem_o   = r_rem_o;
  assign bus.dbz_o   = r_dbz;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes model results, a negedge monitor pops and compares.
module tb_div_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(W)) u_if ();

  div_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           acc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero like DIV/DIVU.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         e;
    longint       la, lb;
    logic [W-1:0] mag;
    int           lz;
    e.q = '0; e.r = '0; e.dbz = 1'b0; e.lat = 1; e.acc = 0; e.tag = "";
    if (b == '0) begin
      e.dbz = 1'b1;
      return e;
    end
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'(a);
      lb = longint'(b);
    end
    e.q = 32'(la / lb);
    e.r = 32'(la % lb);
    mag = (s && a[W-1]) ? -a : a;
    lz  = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
`ifdef DIV_EARLY_TERM_EN
    e.lat = 2 + W - lz;
`else
    e.lat = W + 2;
`endif
    return e;
  endfunction

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (u_if.valid_o && !prev_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(u_if.valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_quot"}, u_if.quot_o, e.q);
          check({e.tag, "_rem"},  u_if.rem_o,  e.r);
          check({e.tag, "_dbz"},  32'(u_if.dbz_o), 32'(e.dbz));
          check({e.tag, "_lat"},  32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev_valid = u_if.valid_o;
    end
  end

  // Called and returns at a negedge; holds ack low for 'hold' DONE cycles while pulsing start.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int hold, input string tag);
    exp_t e;
    int   n;
    e     = model(a, b, s);
    e.acc = cyc;
    e.tag = tag;
    sb.push_back(e);
    u_if.start_i  = 1'b1;
    u_if.signed_i = s;
    u_if.op1_i    = a;
    u_if.op2_i    = b;
    @(negedge clk);
    u_if.start_i  = 1'b0;
    u_if.signed_i = 1'($urandom_range(0, 1));
    u_if.op1_i    = $urandom;
    u_if.op2_i    = $urandom;
    n = 0;
    while (!u_if.valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!u_if.valid_o) begin
      check({tag, "_timeout"}, 32'(u_if.valid_o), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(u_if.valid_o), 32'd1);
      check({tag, "_hold_quot"},  u_if.quot_o, e.q);
      check({tag, "_hold_rem"},   u_if.rem_o,  e.r);
      u_if.start_i = 1'b1;
      u_if.op2_i   = $urandom;
      @(negedge clk);
    end
    u_if.start_i = 1'b0;
    u_if.ack_i   = 1'b1;
    @(negedge clk);
    u_if.ack_i   = 1'b0;
    check({tag, "_post_busy"},  32'(u_if.busy_o),  32'd0);
    check({tag, "_post_valid"}, 32'(u_if.valid_o), 32'd0);
    check({tag, "_post_dbz"},   32'(u_if.dbz_o),   32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           sel;

    rst           = 1'b1;
    u_if.start_i  = 1'b0;
    u_if.signed_i = 1'b0;
    u_if.op1_i    = '0;
    u_if.op2_i    = '0;
    u_if.annul_i  = 1'b0;
    u_if.ack_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(u_if.busy_o),  32'd0);
    check("rst_valid", 32'(u_if.valid_o), 32'd0);
    check("rst_dbz",   32'(u_if.dbz_o),   32'd0);
    check("rst_quot",  u_if.quot_o, 32'd0);
    check("rst_rem",   u_if.rem_o,  32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(32'd100,        32'd7,          1'b0, 0, "u100_7");
    do_op(32'hFFFF_FFF9,  32'd2,          1'b1, 0, "s_m7_2");
    do_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0, "s_min_m1");
    do_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 0, "u_big");
    do_op(32'd5,          32'd0,          1'b0, 0, "dbz_u");
    do_op(32'hFFFF_FFFB,  32'd0,          1'b1, 2, "dbz_s");
    do_op(32'd1234567,    32'd89,         1'b0, 5, "hold5");
    do_op(32'd3,          32'd1,          1'b0, 0, "u3_1");
    do_op(32'd0,          32'd9,          1'b0, 0, "u0_9");

    // Simultaneous start and annul in IDLE must not be accepted.
    u_if.start_i = 1'b1;
    u_if.annul_i = 1'b1;
    u_if.op1_i   = 32'd50;
    u_if.op2_i   = 32'd5;
    @(negedge clk);
    u_if.start_i = 1'b0;
    u_if.annul_i = 1'b0;
    check("start_annul_busy", 32'(u_if.busy_o), 32'd0);

    // Annul on the 10th BUSY cycle, then an immediate new request.
    u_if.start_i  = 1'b1;
    u_if.signed_i = 1'b0;
    u_if.op1_i    = 32'hFFFF_FFF0;
    u_if.op2_i    = 32'd7;
    @(negedge clk);
    u_if.start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("annul_pre_busy", 32'(u_if.busy_o), 32'd1);
    u_if.annul_i = 1'b1;
    @(negedge clk);
    u_if.annul_i = 1'b0;
    check("annul_busy",  32'(u_if.busy_o),  32'd0);
    check("annul_valid", 32'(u_if.valid_o), 32'd0);
    do_op(32'd9, 32'd3, 1'b0, 0, "after_annul");

    // Reset mid-operation returns everything to the reset state.
    u_if.start_i = 1'b1;
    u_if.op1_i   = 32'd1000;
    u_if.op2_i   = 32'd3;
    @(negedge clk);
    u_if.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  32'(u_if.busy_o),  32'd0);
    check("midrst_valid", 32'(u_if.valid_o), 32'd0);
    check("midrst_quot",  u_if.quot_o, 32'd0);
    check("midrst_rem",   u_if.rem_o,  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: a = 32'($urandom_range(0, 255));
        5: a = '0;
        6: b = 32'($urandom_range(1, 1000));
        default: ;
      endcase
      do_op(a, b, s, $urandom_range(0, 3), "rand");
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
